// File: rtl/sbr_table_fl.sv
// Same-bank-request table: free-list allocation, per-entry retire, saturating totals,
// registered CAM lookup and max-total select. Define SBR_AGING_EN to add starvation aging.
module sbr_table_fl #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int BG_W    = 2,
    parameter int BANK_W  = 2,
    parameter int REQ_W   = 8,
    parameter int SRR_W   = 6,
    localparam int ID_W   = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic [BG_W-1:0]   alloc_bg,
    input  logic [BANK_W-1:0] alloc_bank,
    input  logic [SRR_W-1:0]  alloc_head,
    output logic              alloc_done,
    output logic [ID_W-1:0]   alloc_id,
    input  logic              upd_en,
    input  logic [ID_W-1:0]   upd_id,
    input  logic [REQ_W-1:0]  upd_inc,
    input  logic [SRR_W-1:0]  upd_rows,
    input  logic [SRR_W-1:0]  upd_tail,
    input  logic              retire_en,
    input  logic [ID_W-1:0]   retire_id,
    input  logic [ID_W-1:0]   rd_id,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [BG_W-1:0]   rd_bg,
    output logic [BANK_W-1:0] rd_bank,
    output logic [REQ_W-1:0]  rd_total,
    output logic [SRR_W-1:0]  rd_rows,
    output logic [SRR_W-1:0]  rd_head,
    output logic [SRR_W-1:0]  rd_tail,
    input  logic              lookup_en,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              lookup_hit,
    output logic [ID_W-1:0]   lookup_id,
    input  logic              select_req,
    output logic              select_valid,
    output logic [ID_W-1:0]   select_id,
    output logic [REQ_W-1:0]  select_total,
    output logic [ID_W:0]     count,
    output logic              full,
    output logic              empty
);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem   [ENTRIES];
    logic [BG_W-1:0]    bg_mem    [ENTRIES];
    logic [BANK_W-1:0]  bank_mem  [ENTRIES];
    logic [REQ_W-1:0]   total_mem [ENTRIES];
    logic [SRR_W-1:0]   rows_mem  [ENTRIES];
    logic [SRR_W-1:0]   head_mem  [ENTRIES];
    logic [SRR_W-1:0]   tail_mem  [ENTRIES];

    logic               accept;
    logic               retire_eff;
    logic               upd_eff;
    logic [ID_W-1:0]    free_id;
    logic [REQ_W:0]     upd_sum;
    logic [REQ_W-1:0]   upd_total;
    logic               lk_hit_c;
    logic [ID_W-1:0]    lk_id_c;
    logic [ENTRIES-1:0] cand;
    logic               sel_found;
    logic [ID_W-1:0]    sel_id_c;
    logic [REQ_W-1:0]   sel_total_c;

    assign full        = (count == (ID_W+1)'(ENTRIES));
    assign empty       = (count == '0);
    assign alloc_ready = ~full;
    assign accept      = alloc_valid & ~full & ~clear;
    assign retire_eff  = retire_en & valid[retire_id] & ~clear;
    // An update racing a retire of the same entry is discarded.
    assign upd_eff     = upd_en & valid[upd_id] & ~clear & ~(retire_en && (retire_id == upd_id));
    assign upd_sum     = {1'b0, total_mem[upd_id]} + {1'b0, upd_inc};
    assign upd_total   = upd_sum[REQ_W] ? '1 : upd_sum[REQ_W-1:0];

    always_comb begin
        logic found;
        found   = 1'b0;
        free_id = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid[i] && !found) begin
                found   = 1'b1;
                free_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        lk_hit_c = 1'b0;
        lk_id_c  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid[i] && (tag_mem[i] == lookup_tag) && !lk_hit_c) begin
                lk_hit_c = 1'b1;
                lk_id_c  = ID_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            cand[i] = valid[i] && (total_mem[i] != '0);
        end
    end

`ifdef SBR_AGING_EN
    logic [3:0] age_mem [ENTRIES];
`endif

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        sel_found   = 1'b0;
        sel_id_c    = '0;
        sel_total_c = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (cand[i] && (total_mem[i] > sel_total_c)) begin
                sel_found   = 1'b1;
                sel_id_c    = ID_W'(i);
                sel_total_c = total_mem[i];
            end
        end
`ifdef SBR_AGING_EN
        begin
            logic aged;
            aged = 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                if (cand[i] && (age_mem[i] == 4'hF) && !aged) begin
                    aged        = 1'b1;
                    sel_id_c    = ID_W'(i);
                    sel_total_c = total_mem[i];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            count <= '0;
        end else if (clear) begin
            valid <= '0;
            count <= '0;
        end else begin
            if (accept)     valid[free_id]   <= 1'b1;
            if (retire_eff) valid[retire_id] <= 1'b0;
            count <= count + (ID_W+1)'(accept) - (ID_W+1)'(retire_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[free_id]   <= alloc_tag;
            bg_mem[free_id]    <= alloc_bg;
            bank_mem[free_id]  <= alloc_bank;
            head_mem[free_id]  <= alloc_head;
            tail_mem[free_id]  <= alloc_head;
            total_mem[free_id] <= '0;
            rows_mem[free_id]  <= '0;
        end
        if (upd_eff) begin
            total_mem[upd_id] <= upd_total;
            rows_mem[upd_id]  <= upd_rows;
            tail_mem[upd_id]  <= upd_tail;
        end
    end

`ifdef SBR_AGING_EN
    always_ff @(posedge clk) begin
        if (select_req && sel_found && !clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (ID_W'(i) == sel_id_c)           age_mem[i] <= 4'h0;
                else if (cand[i] && age_mem[i] != 4'hF) age_mem[i] <= age_mem[i] + 4'h1;
            end
        end
        if (accept) age_mem[free_id] <= 4'h0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_done   <= 1'b0;
            alloc_id     <= '0;
            lookup_hit   <= 1'b0;
            lookup_id    <= '0;
            select_valid <= 1'b0;
            select_id    <= '0;
            select_total <= '0;
            rd_valid     <= 1'b0;
            rd_tag       <= '0;
            rd_bg        <= '0;
            rd_bank      <= '0;
            rd_total     <= '0;
            rd_rows      <= '0;
            rd_head      <= '0;
            rd_tail      <= '0;
        end else begin
            rd_valid <= valid[rd_id];
            rd_tag   <= tag_mem[rd_id];
            rd_bg    <= bg_mem[rd_id];
            rd_bank  <= bank_mem[rd_id];
            rd_total <= total_mem[rd_id];
            rd_rows  <= rows_mem[rd_id];
            rd_head  <= head_mem[rd_id];
            rd_tail  <= tail_mem[rd_id];
            if (clear) begin
                alloc_done   <= 1'b0;
                lookup_hit   <= 1'b0;
                lookup_id    <= '0;
                select_valid <= 1'b0;
                select_id    <= '0;
                select_total <= '0;
            end else begin
                alloc_done <= accept;
                if (accept) alloc_id <= free_id;
                lookup_hit <= lookup_en & lk_hit_c;
                lookup_id  <= lookup_en ? lk_id_c : '0;
                if (select_req) begin
                    select_valid <= sel_found;
                    select_id    <= sel_id_c;
                    select_total <= sel_total_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbr_table_fl.sv
// Scoreboard bench for sbr_table_fl: a behavioural table model predicts every registered
// output one cycle ahead; directed scenarios followed by a random phase.
module tb_sbr_table_fl;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [7:0] alloc_tag;
    logic [1:0] alloc_bg;
    logic [1:0] alloc_bank;
    logic [5:0] alloc_head;
    logic       alloc_done;
    logic [3:0] alloc_id;
    logic       upd_en;
    logic [3:0] upd_id;
    logic [7:0] upd_inc;
    logic [5:0] upd_rows;
    logic [5:0] upd_tail;
    logic       retire_en;
    logic [3:0] retire_id;
    logic [3:0] rd_id;
    logic       rd_valid;
    logic [7:0] rd_tag;
    logic [1:0] rd_bg;
    logic [1:0] rd_bank;
    logic [7:0] rd_total;
    logic [5:0] rd_rows;
    logic [5:0] rd_head;
    logic [5:0] rd_tail;
    logic       lookup_en;
    logic [7:0] lookup_tag;
    logic       lookup_hit;
    logic [3:0] lookup_id;
    logic       select_req;
    logic       select_valid;
    logic [3:0] select_id;
    logic [7:0] select_total;
    logic [4:0] count;
    logic       full;
    logic       empty;

    sbr_table_fl dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_bg(alloc_bg), .alloc_bank(alloc_bank), .alloc_head(alloc_head),
        .alloc_done(alloc_done), .alloc_id(alloc_id),
        .upd_en(upd_en), .upd_id(upd_id), .upd_inc(upd_inc), .upd_rows(upd_rows), .upd_tail(upd_tail),
        .retire_en(retire_en), .retire_id(retire_id),
        .rd_id(rd_id), .rd_valid(rd_valid), .rd_tag(rd_tag), .rd_bg(rd_bg), .rd_bank(rd_bank),
        .rd_total(rd_total), .rd_rows(rd_rows), .rd_head(rd_head), .rd_tail(rd_tail),
        .lookup_en(lookup_en), .lookup_tag(lookup_tag), .lookup_hit(lookup_hit), .lookup_id(lookup_id),
        .select_req(select_req), .select_valid(select_valid), .select_id(select_id),
        .select_total(select_total), .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the table.
    bit         m_valid   [16];
    bit         m_written [16];
    logic [7:0] m_tag     [16];
    logic [1:0] m_bg      [16];
    logic [1:0] m_bank    [16];
    int         m_total   [16];
    logic [5:0] m_rows    [16];
    logic [5:0] m_head    [16];
    logic [5:0] m_tail    [16];
    int         m_age     [16];
    int         m_count = 0;
    logic       s_valid = 1'b0;
    logic [3:0] s_id    = 4'd0;
    logic [7:0] s_total = 8'd0;

    logic [4:0]  alloc_q [$];
    logic [4:0]  look_q  [$];
    logic [12:0] sel_q   [$];
    logic [39:0] rd_q    [$];

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic idle();
        clear = 0; alloc_valid = 0; alloc_tag = 0; alloc_bg = 0; alloc_bank = 0; alloc_head = 0;
        upd_en = 0; upd_id = 0; upd_inc = 0; upd_rows = 0; upd_tail = 0;
        retire_en = 0; retire_id = 0; rd_id = 0;
        lookup_en = 0; lookup_tag = 0; select_req = 0;
    endtask

    // Predict outputs from pre-edge model state, advance the model, clock, then compare.
    task automatic cycle();
        int slot, best, bt, lid, r;
        bit acc, ret, upd, lhit, found;
        logic [4:0]  a;
        logic [4:0]  l;
        logic [12:0] s;
        logic [39:0] d;
        slot = -1;
        for (int i = 0; i < 16; i++) if (!m_valid[i] && slot < 0) slot = i;
        acc = alloc_valid && (m_count < 16) && !clear;
        alloc_q.push_back({acc, acc ? 4'(slot) : 4'd0});
        r = int'(rd_id);
        rd_q.push_back({m_written[r], m_valid[r], m_tag[r], m_bg[r], m_bank[r], 8'(m_total[r]),
                        m_rows[r], m_head[r], m_tail[r]});
        lhit = 0; lid = 0;
        if (lookup_en && !clear)
            for (int i = 0; i < 16; i++)
                if (m_valid[i] && m_tag[i] == lookup_tag && !lhit) begin lhit = 1; lid = i; end
        look_q.push_back({lhit, 4'(lid)});
        if (clear) begin
            s_valid = 0; s_id = 0; s_total = 0;
        end else if (select_req) begin
            found = 0; best = 0; bt = 0;
            for (int i = 0; i < 16; i++)
                if (m_valid[i] && m_total[i] > bt) begin found = 1; best = i; bt = m_total[i]; end
`ifdef SBR_AGING_EN
            for (int i = 15; i >= 0; i--)
                if (m_valid[i] && m_total[i] > 0 && m_age[i] == 15) begin best = i; bt = m_total[i]; end
            if (found)
                for (int i = 0; i < 16; i++)
                    if (i == best) m_age[i] = 0;
                    else if (m_valid[i] && m_total[i] > 0 && m_age[i] < 15) m_age[i]++;
`endif
            s_valid = found; s_id = 4'(best); s_total = 8'(bt);
        end
        sel_q.push_back({s_valid, s_id, s_total});
        if (clear) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            m_count = 0;
        end else begin
            ret = retire_en && m_valid[retire_id];
            upd = upd_en && m_valid[upd_id] && !(retire_en && retire_id == upd_id);
            if (upd) begin
                m_total[upd_id] = (m_total[upd_id] + int'(upd_inc) > 255) ? 255 : m_total[upd_id] + int'(upd_inc);
                m_rows[upd_id] = upd_rows;
                m_tail[upd_id] = upd_tail;
            end
            if (acc) begin
                m_valid[slot] = 1; m_written[slot] = 1; m_tag[slot] = alloc_tag; m_bg[slot] = alloc_bg;
                m_bank[slot] = alloc_bank; m_head[slot] = alloc_head; m_tail[slot] = alloc_head;
                m_total[slot] = 0; m_rows[slot] = 0; m_age[slot] = 0;
            end
            if (ret) m_valid[retire_id] = 0;
            m_count = m_count + int'(acc) - int'(ret);
        end
        @(posedge clk);
        #1;
        a = alloc_q.pop_front();
        check_eq("alloc_done", alloc_done, a[4]);
        if (a[4]) check_eq("alloc_id", alloc_id, a[3:0]);
        l = look_q.pop_front();
        check_eq("lookup", {lookup_hit, lookup_id}, l);
        s = sel_q.pop_front();
        check_eq("select", {select_valid, select_id, select_total}, s);
        d = rd_q.pop_front();
        if (d[39]) check_eq("rd", {rd_valid, rd_tag, rd_bg, rd_bank, rd_total, rd_rows, rd_head, rd_tail}, d[38:0]);
        else       check_eq("rd_valid", rd_valid, d[38]);
        check_eq("count", count, m_count);
        check_eq("full", full, m_count == 16);
        check_eq("empty", empty, m_count == 0);
        check_eq("alloc_ready", alloc_ready, m_count != 16);
    endtask

    task automatic do_alloc(input logic [7:0] tag);
        idle(); alloc_valid = 1; alloc_tag = tag; alloc_bg = tag[1:0]; alloc_bank = tag[3:2];
        alloc_head = tag[5:0]; cycle(); idle();
    endtask

    task automatic do_update(input logic [3:0] id, input logic [7:0] inc);
        idle(); upd_en = 1; upd_id = id; upd_inc = inc;
        upd_rows = 6'($urandom_range(0, 63)); upd_tail = 6'($urandom_range(0, 63)); cycle(); idle();
    endtask

    task automatic do_retire(input logic [3:0] id);
        idle(); retire_en = 1; retire_id = id; cycle(); idle();
    endtask

    task automatic do_read(input logic [3:0] id);
        idle(); rd_id = id; cycle(); idle();
    endtask

    task automatic do_lookup(input logic [7:0] tag);
        idle(); lookup_en = 1; lookup_tag = tag; cycle(); idle();
    endtask

    task automatic do_select();
        idle(); select_req = 1; cycle(); idle();
    endtask

    initial begin
        int k;
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", count, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_alloc_done", alloc_done, 0);
        check_eq("rst_outs", {rd_valid, rd_total, lookup_hit, select_valid, select_total}, 0);
        rst_n = 1;

        do_alloc(8'h11); do_alloc(8'h22); do_alloc(8'h33);
        check_eq("three_count", count, 3);
        for (int i = 3; i < 16; i++) do_alloc(i == 4 ? 8'h22 : 8'(8'h40 + i));
        check_eq("full_flag", full, 1);
        do_alloc(8'h77);

        do_retire(4'd5);
        idle(); alloc_valid = 1; alloc_tag = 8'h45; retire_en = 1; retire_id = 4'd8; cycle(); idle();
        check_eq("reuse_id5", alloc_id, 5);
        do_retire(4'd8);
        do_alloc(8'h48);

        do_update(4'd1, 8'd200); do_update(4'd1, 8'd200); do_read(4'd1);
        check_eq("sat_total", rd_total, 255);
        do_retire(4'd9); do_update(4'd9, 8'd30); do_read(4'd9);

        do_lookup(8'h22);
        check_eq("dup_lookup_id", lookup_id, 1);
        do_lookup(8'h99);

        idle(); upd_en = 1; upd_id = 4'd1; upd_inc = 8'd5; retire_en = 1; retire_id = 4'd1; cycle(); idle();
        do_update(4'd0, 8'd7); do_update(4'd2, 8'd12); do_update(4'd3, 8'd12);
        do_select();
        check_eq("sel_tie_id", select_id, 2);
        do_retire(4'd0); do_retire(4'd2); do_retire(4'd3);
        do_select();
        check_eq("sel_none", select_valid, 0);

        for (int n = 0; n < 300; n++) begin
            idle();
            alloc_valid = ($urandom_range(0, 2) != 0);
            alloc_tag = 8'($urandom_range(8'h40, 8'h7f));
            alloc_bg = 2'($urandom_range(0, 3)); alloc_bank = 2'($urandom_range(0, 3));
            alloc_head = 6'($urandom_range(0, 63));
            retire_en = ($urandom_range(0, 2) == 0); retire_id = 4'($urandom_range(0, 15));
            upd_en = ($urandom_range(0, 1) == 1); upd_id = 4'($urandom_range(0, 15));
            upd_inc = 8'($urandom_range(0, 60));
            upd_rows = 6'($urandom_range(0, 63)); upd_tail = 6'($urandom_range(0, 63));
            lookup_en = ($urandom_range(0, 1) == 1);
            k = $urandom_range(0, 15);
            lookup_tag = m_written[k] ? m_tag[k] : 8'($urandom_range(0, 255));
            select_req = ($urandom_range(0, 2) == 0);
            rd_id = 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 49) == 0);
            cycle();
        end
        idle();

        for (int i = 0; i < 16; i++) if (!full) do_alloc(8'(8'h50 + i));
        idle(); clear = 1; alloc_valid = 1; alloc_tag = 8'h66; cycle(); idle();
        check_eq("clear_count", count, 0);
        check_eq("clear_alloc_done", alloc_done, 0);
        for (int i = 0; i < 16; i++) do_read(4'(i));

`ifdef SBR_AGING_EN
        do_alloc(8'h0a); do_alloc(8'h0b);
        do_update(4'd0, 8'd1); do_update(4'd1, 8'd50);
        for (int i = 0; i < 15; i++) do_select();
        do_select();
        check_eq("aged_winner", select_id, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
